// File: rtl/mem_wb_skid_reg.sv
// mem_wb_skid_reg: elastic MEM/WB pipeline register.
// Two-entry skid buffer (main + skid) between the MEM stage and the
// register-file write port. in_ready is a flop, so there is no
// combinational path from out_ready back to the MEM stage.
// Flush squashes valid state only; payload registers keep stale values,
// and out_wren is gated by out_valid so stale data never writes back.
module mem_wb_skid_reg #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 6,
  parameter int DST_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DST_W-1:0]  in_dst,
  input  logic              in_wren,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DST_W-1:0]  out_dst,
  output logic              out_wren,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Occupancy doubles as the state encoding.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic [DST_W-1:0]  dst;
    logic              wren;
  } entry_t;

  state_t state, state_nxt;
  entry_t main_q, skid_q, in_ent;
  logic   in_ready_q;
  logic   accept, emit;
  logic   load_main_in, load_main_skid, load_skid;

  assign in_ent    = {in_data, in_ctrl, in_dst, in_wren};
  assign out_valid = (state != EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid & in_ready_q;
  assign emit      = out_valid & out_ready;

  assign out_data  = main_q.data;
  assign out_ctrl  = main_q.ctrl;
  assign out_dst   = main_q.dst;
  assign out_wren  = main_q.wren & out_valid;
  assign occupancy = state;

  // Next-state and register load selects; flush overrides every handshake.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_nxt    = ONE;
          end
        end
        ONE: begin
          if (accept && emit) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else if (emit) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only an emit can move the state.
          if (emit) begin
            load_main_skid = 1'b1;
            state_nxt      = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // State register and registered ready; ready low while in reset and when FULL.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != FULL);
    end
  end

  // Payload registers: main drives the outputs, skid catches the overflow entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)
        main_q <= in_ent;
      else if (load_main_skid)
        main_q <= skid_q;
      if (load_skid)
        skid_q <= in_ent;
    end
  end

  // Saturating stall counter; survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Directed bench for mem_wb_skid_reg with a decoupled scoreboard:
// the driver pushes each accepted vector, the monitor pops on every emit.
module tb_mem_wb_skid_reg;
  localparam int DW = 16;
  localparam int CW = 6;
  localparam int SW = 3;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic [SW-1:0] in_dst = '0;
  logic          in_wren = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [SW-1:0] out_dst;
  logic          out_wren;
  logic          flush = 1'b0;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt;

  mem_wb_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .DST_W(SW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_dst(in_dst), .in_wren(in_wren),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_dst(out_dst), .out_wren(out_wren),
    .flush(flush), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
    logic [SW-1:0] dst;
    logic          wren;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t drv_e;
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  // Monitor: every emit must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mon_unexpected got=%0h want=none", out_data);
        end else begin
          mon_e = sb.pop_front();
          chk("mon_entry", {6'd0, out_data, out_ctrl, out_dst, out_wren}, {6'd0, mon_e});
        end
      end
      if (flush) sb.delete();
    end
  end

  task automatic drive(input logic [DW-1:0] d, input logic [SW-1:0] dst, input logic w);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = d[7:2];
    in_dst   = dst;
    in_wren  = w;
  endtask

  // One clock: record an accepted vector as expected, then advance past the edge.
  task automatic step();
    @(negedge clk);
    if (rst && !flush && in_valid && in_ready) begin
      drv_e = {in_data, in_ctrl, in_dst, in_wren};
      sb.push_back(drv_e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_wren", 32'(out_wren), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ctrl", 32'(out_ctrl), 32'd0);
    chk("rst_dst", 32'(out_dst), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Stream 0x1111..0x1114 with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(DW'(16'h1111 + i), SW'(i), 1'b1);
      step();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_data", 32'(out_data), 32'(16'h1111 + i));
      chk("stream_occ_le1", 32'(occupancy <= 2'd1), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drained", 32'(out_valid), 32'd0);
    chk("stream_stall", 32'(stall_cnt), 32'd0);

    // Back-pressure
    out_ready = 1'b0;
    drive(16'hA001, 3'd1, 1'b1);
    step();
    chk("bp_occ1", 32'(occupancy), 32'd1);
    drive(16'hA002, 3'd2, 1'b1);
    step();
    chk("bp_occ2", 32'(occupancy), 32'd2);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    drive(16'hA003, 3'd3, 1'b1);
    step();
    chk("bp_rejected_occ", 32'(occupancy), 32'd2);
    chk("bp_head", 32'(out_data), 32'hA001);
    out_ready = 1'b1;
    step();
    chk("bp_head2", 32'(out_data), 32'hA002);
    chk("bp_in_ready_up", 32'(in_ready), 32'd1);
    step();
    chk("bp_head3", 32'(out_data), 32'hA003);
    chk("bp_occ_one", 32'(occupancy), 32'd1);
    in_valid = 1'b0;
    step();
    chk("bp_empty", 32'(occupancy), 32'd0);
    chk("bp_stall", 32'(stall_cnt), 32'd2);

    // Flush when FULL with an entry offered in the same cycle
    out_ready = 1'b0;
    drive(16'hB001, 3'd4, 1'b1);
    step();
    drive(16'hB002, 3'd5, 1'b1);
    step();
    chk("fl_full", 32'(occupancy), 32'd2);
    drive(16'hB003, 3'd6, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_wren", 32'(out_wren), 32'd0);
    chk("fl_occ", 32'(occupancy), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) step();
    chk("fl_no_b003", 32'(out_valid), 32'd0);
    chk("fl_stall_kept", 32'(stall_cnt), 32'd4);

    // Flush in ONE with an emit and an offered entry in the same cycle
    out_ready = 1'b0;
    drive(16'hF001, 3'd7, 1'b0);
    step();
    chk("f1_valid", 32'(out_valid), 32'd1);
    chk("f1_wren_gated_by_store", 32'(out_wren), 32'd0);
    out_ready = 1'b1;
    drive(16'hF002, 3'd1, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("f1_occ", 32'(occupancy), 32'd0);
    chk("f1_valid_after", 32'(out_valid), 32'd0);

    // wren gating and stale dst
    out_ready = 1'b0;
    drive(16'hC005, 3'd5, 1'b1);
    step();
    chk("wr_wren_on", 32'(out_wren), 32'd1);
    chk("wr_dst", 32'(out_dst), 32'd5);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("wr_valid_off", 32'(out_valid), 32'd0);
    chk("wr_wren_off", 32'(out_wren), 32'd0);
    chk("wr_dst_stale", 32'(out_dst), 32'd5);
    chk("wr_stall", 32'(stall_cnt), 32'd4);

    // Counter saturation (CNT_W=4): 4 + 10 = 14, then clamps at 15
    out_ready = 1'b0;
    drive(16'hD001, 3'd2, 1'b1);
    step();
    in_valid = 1'b0;
    repeat (10) step();
    chk("sat_14", 32'(stall_cnt), 32'd14);
    repeat (10) step();
    chk("sat_15", 32'(stall_cnt), 32'd15);

    // Reset while FULL
    drive(16'hD002, 3'd3, 1'b1);
    step();
    chk("mr_full", 32'(occupancy), 32'd2);
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_occ", 32'(occupancy), 32'd0);
    chk("mr_wren", 32'(out_wren), 32'd0);
    chk("mr_data", 32'(out_data), 32'd0);
    chk("mr_ctrl", 32'(out_ctrl), 32'd0);
    chk("mr_dst", 32'(out_dst), 32'd0);
    chk("mr_stall", 32'(stall_cnt), 32'd0);
    chk("mr_in_ready_low", 32'(in_ready), 32'd0);
    rst = 1'b1;
    step();
    chk("mr_in_ready_up", 32'(in_ready), 32'd1);
    chk("mr_occ_after", 32'(occupancy), 32'd0);

    // Buffer still works after the mid-operation reset
    out_ready = 1'b1;
    drive(16'hE001, 3'd1, 1'b1);
    step();
    chk("post_data", 32'(out_data), 32'hE001);
    in_valid = 1'b0;
    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
